// File: rtl/tdc_shot_scheduler.sv
// Frame sequencer for a TDC: per shot it issues a start strobe, counts gate hits in a window,
// drains TDC output when hits occurred, then waits a dead-time. Optional macro: DRAIN_TIMEOUT_EN.
module tdc_shot_scheduler #(
    parameter int START_W = 2,
    parameter int GAP_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_auto,
    input  logic        frame_req,
    input  logic [7:0]  shot_num,
    input  logic [14:0] range_i,
    input  logic        tgate,
    input  logic        TDC_Ovalid,
    input  logic        TDC_Olast,
    output logic        TDC_start,
    output logic        TDC_Oready,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  hit_cnt,
    output logic [7:0]  shot_cnt,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WINDOW,
        S_DRAIN,
        S_GAP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  shots_q;
    logic [14:0] range_q;
    logic [7:0]  phase_cnt;
    logic [14:0] win_cnt;
    logic        tg_meta;
    logic        tg_sync;
    logic        tg_prev;
    logic        tg_rise;
    logic [1:0]  hit_nxt;
    logic        accept;
    logic        start_last;
    logic        win_last;
    logic        gap_last;
    logic        last_shot;
    logic        olast_beat;
    logic        drain_to;

    assign accept     = (state == S_IDLE) && frame_req;
    assign tg_rise    = tg_sync && !tg_prev;
    assign start_last = (phase_cnt == 8'(START_W - 1));
    assign gap_last   = (phase_cnt == 8'(GAP_W - 1));
    assign win_last   = (win_cnt == range_q);
    assign last_shot  = (({1'b0, shot_cnt} + 9'd1) == {1'b0, shots_q});
    assign olast_beat = (state == S_DRAIN) && TDC_Ovalid && TDC_Olast;

    // Saturating hit count including an edge seen in the current cycle, so a hit
    // synchronised in the final window cycle still steers the FSM into DRAIN.
    always_comb begin
        hit_nxt = hit_cnt;
        if (tg_rise && (hit_cnt != 2'd3)) hit_nxt = hit_cnt + 2'd1;
    end

    // NOTE: state and counters use non-blocking assignments with an asynchronous,
    // active-low reset so every flop clears the instant rst_auto falls.
    always_ff @(posedge clk or negedge rst_auto) begin
        if (!rst_auto) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        TDC_start  = 1'b0;
        TDC_Oready = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (frame_req) state_nxt = S_START;
            end
            S_START: begin
                TDC_start = 1'b1;
                if (start_last) state_nxt = S_WINDOW;
            end
            S_WINDOW: begin
                if (win_last) state_nxt = (hit_nxt != 2'd0) ? S_DRAIN : S_GAP;
            end
            S_DRAIN: begin
                TDC_Oready = 1'b1;
                if (olast_beat || drain_to) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_last) state_nxt = last_shot ? S_DONE : S_START;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_auto) begin
        if (!rst_auto) begin
            tg_meta   <= 1'b0;
            tg_sync   <= 1'b0;
            tg_prev   <= 1'b0;
            shots_q   <= '0;
            range_q   <= '0;
            phase_cnt <= '0;
            win_cnt   <= '0;
            hit_cnt   <= '0;
            shot_cnt  <= '0;
        end else begin
            tg_meta <= tgate;
            tg_sync <= tg_meta;
            tg_prev <= tg_sync;

            // phase_cnt times both START and GAP; it restarts on every state change.
            if ((state_nxt == state) && ((state == S_START) || (state == S_GAP)))
                phase_cnt <= phase_cnt + 8'd1;
            else
                phase_cnt <= '0;

            if ((state == S_WINDOW) && !win_last) win_cnt <= win_cnt + 15'd1;
            else                                  win_cnt <= '0;

            if (accept) begin
                shots_q  <= (shot_num == 8'd0) ? 8'd1 : shot_num;
                range_q  <= range_i;
                shot_cnt <= '0;
                hit_cnt  <= '0;
            end else if ((state == S_START) && start_last) begin
                hit_cnt <= '0;
            end else if (state == S_WINDOW) begin
                hit_cnt <= hit_nxt;
            end else if ((state == S_GAP) && gap_last && !last_shot) begin
                shot_cnt <= shot_cnt + 8'd1;
            end
        end
    end

`ifdef DRAIN_TIMEOUT_EN
    localparam int DRAIN_W = $clog2(TIMEOUT + 1);

    logic [DRAIN_W-1:0] drain_cnt;

    assign drain_to = (state == S_DRAIN) && !olast_beat && (drain_cnt == DRAIN_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_auto) begin
        if (!rst_auto) begin
            drain_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if ((state == S_DRAIN) && !olast_beat && !drain_to)
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            else
                drain_cnt <= '0;

            if (accept)        err <= 1'b0;
            else if (drain_to) err <= 1'b1;
        end
    end
`else
    assign drain_to = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_shot_scheduler.sv
// Self-checking bench for tdc_shot_scheduler: per-frame expected timelines are built from the
// shot/window/drain/gap rules and compared cycle by cycle against the DUT outputs.
module tb_tdc_shot_scheduler;

    localparam int START_W = 2;
    localparam int GAP_W   = 4;
    localparam int TIMEOUT = 1024;
    localparam int MAXC    = 2048;

    logic        clk;
    logic        rst_auto;
    logic        frame_req;
    logic [7:0]  shot_num;
    logic [14:0] range_i;
    logic        tgate;
    logic        TDC_Ovalid;
    logic        TDC_Olast;
    logic        TDC_start;
    logic        TDC_Oready;
    logic        busy;
    logic        frame_done;
    logic [1:0]  hit_cnt;
    logic [7:0]  shot_cnt;
    logic        err;

    tdc_shot_scheduler #(
        .START_W (START_W),
        .GAP_W   (GAP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_auto   (rst_auto),
        .frame_req  (frame_req),
        .shot_num   (shot_num),
        .range_i    (range_i),
        .tgate      (tgate),
        .TDC_Ovalid (TDC_Ovalid),
        .TDC_Olast  (TDC_Olast),
        .TDC_start  (TDC_start),
        .TDC_Oready (TDC_Oready),
        .busy       (busy),
        .frame_done (frame_done),
        .hit_cnt    (hit_cnt),
        .shot_cnt   (shot_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Expected timeline of one frame, indexed by cycle after the accepting edge.
    bit tg_a      [MAXC];
    bit ov_a      [MAXC];
    bit ol_a      [MAXC];
    bit exp_start [MAXC];
    bit exp_ready [MAXC];
    int exp_hit   [MAXC];
    int exp_shot  [MAXC];

    int obs_start_high;
    int obs_start_rise;
    int obs_ready_cnt;
    int obs_done_cnt;
    int obs_done_c;

    task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h, expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_start"}, -1, 32'(TDC_start), 0);
        check({tag, "_ready"}, -1, 32'(TDC_Oready), 0);
        check({tag, "_busy"},  -1, 32'(busy), 0);
        check({tag, "_done"},  -1, 32'(frame_done), 0);
        check({tag, "_hit"},   -1, 32'(hit_cnt), 0);
        check({tag, "_shot"},  -1, 32'(shot_cnt), 0);
        check({tag, "_err"},   -1, 32'(err), 0);
    endtask

    // odly < 0 means Olast is never offered, so DRAIN can only end by timeout.
    // abort_mode 1/2 pulses rst_auto in the middle of shot 0's WINDOW/DRAIN.
    task automatic run_frame(input int shots_in, input int rng, input int npulse,
                             input int first_off, input int odly, input int abort_mode);
        int shots, t, win, hits, prev_hits, dl, d0, abort_c, done_c, last_c, err_from, off, a, n;
        int offs[$];
        logic prev_start;

        shots = (shots_in == 0) ? 1 : shots_in;
        for (int i = 0; i < MAXC; i++) begin
            tg_a[i]      = 1'b0;
            ov_a[i]      = 1'($urandom);
            ol_a[i]      = 1'($urandom);
            exp_start[i] = 1'b0;
            exp_ready[i] = 1'b0;
            exp_hit[i]   = 0;
            exp_shot[i]  = 0;
        end
        t         = 0;
        prev_hits = 0;
        abort_c   = -1;
        err_from  = MAXC;

        for (int s = 0; s < shots; s++) begin
            for (int i = 0; i < START_W; i++) begin
                exp_start[t] = 1'b1;
                exp_shot[t]  = s;
                exp_hit[t]   = prev_hits;
                t++;
            end
            win = t;
            // Gate pulses: 2 cycles high, 5-cycle pitch; a rise driven in cycle a is seen
            // after two sync flops, i.e. belongs to window offset a + 2 - win.
            offs.delete();
            for (int p = 0; p < npulse; p++) begin
                off = first_off + 5 * p;
                a   = win + off - 2;
                if ((off <= rng + 1) && (a >= 0)) begin
                    tg_a[a]     = 1'b1;
                    tg_a[a + 1] = 1'b1;
                    if ((off >= 0) && (off <= rng)) offs.push_back(off);
                end
            end
            for (int k = 0; k <= rng; k++) begin
                n = 0;
                foreach (offs[j]) if (offs[j] < k) n++;
                exp_shot[t] = s;
                exp_hit[t]  = (n > 3) ? 3 : n;
                t++;
            end
            hits = (offs.size() > 3) ? 3 : offs.size();
            if ((abort_mode == 1) && (s == 0)) abort_c = win + rng / 2;
            if (hits != 0) begin
                d0 = t;
                dl = (odly < 0) ? TIMEOUT : odly + 1;
`ifdef DRAIN_TIMEOUT_EN
                if (odly < 0) err_from = d0 + TIMEOUT;
`endif
                for (int i = 0; i < dl; i++) begin
                    exp_ready[t] = 1'b1;
                    exp_shot[t]  = s;
                    exp_hit[t]   = hits;
                    case ($urandom_range(0, 2))
                        0:       begin ov_a[t] = 1'b0; ol_a[t] = 1'b0; end
                        1:       begin ov_a[t] = 1'b1; ol_a[t] = 1'b0; end
                        default: begin ov_a[t] = 1'b0; ol_a[t] = 1'b1; end
                    endcase
                    if ((odly >= 0) && (i == dl - 1)) begin
                        ov_a[t] = 1'b1;
                        ol_a[t] = 1'b1;
                    end
                    t++;
                end
                if ((abort_mode == 2) && (s == 0)) abort_c = d0 + dl / 2;
            end
            for (int i = 0; i < GAP_W; i++) begin
                exp_shot[t] = s;
                exp_hit[t]  = hits;
                t++;
            end
            prev_hits = hits;
        end
        done_c = t;
        last_c = done_c + 3;
        for (int i = done_c; i <= last_c; i++) begin
            exp_shot[i] = shots - 1;
            exp_hit[i]  = prev_hits;
        end

        frame_req  = 1'b1;
        shot_num   = 8'(shots_in);
        range_i    = 15'(rng);
        tgate      = 1'b0;
        TDC_Ovalid = 1'b0;
        TDC_Olast  = 1'b0;
        @(posedge clk);
        obs_start_high = 0;
        obs_start_rise = 0;
        obs_ready_cnt  = 0;
        obs_done_cnt   = 0;
        obs_done_c     = -1;
        prev_start     = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            #1;
            frame_req  = (c <= done_c) ? 1'($urandom) : 1'b0;
            shot_num   = 8'($urandom);
            range_i    = 15'($urandom);
            tgate      = tg_a[c];
            TDC_Ovalid = ov_a[c];
            TDC_Olast  = ol_a[c];
            @(negedge clk);
            check("TDC_start",  c, 32'(TDC_start),  32'(exp_start[c]));
            check("TDC_Oready", c, 32'(TDC_Oready), 32'(exp_ready[c]));
            check("busy",       c, 32'(busy),       32'(c <= done_c));
            check("frame_done", c, 32'(frame_done), 32'(c == done_c));
            check("hit_cnt",    c, 32'(hit_cnt),    32'(exp_hit[c]));
            check("shot_cnt",   c, 32'(shot_cnt),   32'(exp_shot[c]));
            check("err",        c, 32'(err),        32'(c >= err_from));
            if (TDC_start) obs_start_high++;
            if (TDC_start && !prev_start) obs_start_rise++;
            prev_start = TDC_start;
            if (TDC_Oready) obs_ready_cnt++;
            if (frame_done) begin
                obs_done_cnt++;
                obs_done_c = c;
            end
            if (c == abort_c) begin
                #2;
                rst_auto = 1'b0;
                #1;
                check_reset("abort");
                tgate     = 1'b0;
                frame_req = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("abort_hold_busy", c, 32'(busy), 0);
                rst_auto = 1'b1;
                return;
            end
            if (c < last_c) @(posedge clk);
        end
    endtask

    initial begin
        rst_auto   = 1'b0;
        frame_req  = 1'b0;
        shot_num   = '0;
        range_i    = '0;
        tgate      = 1'b0;
        TDC_Ovalid = 1'b0;
        TDC_Olast  = 1'b0;
        #3;
        check_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst_auto = 1'b1;

        // One shot, range 100, no hits: 2 start cycles, 101 window, 4 gap, then DONE.
        run_frame(1, 100, 0, 0, 0, 0);
        check("r032_start_cycles", -1, obs_start_high, 2);
        check("r032_start_pulses", -1, obs_start_rise, 1);
        check("r032_done_cycle",   -1, obs_done_c, START_W + 101 + GAP_W);
        check("r032_done_count",   -1, obs_done_cnt, 1);
        check("r032_no_drain",     -1, obs_ready_cnt, 0);

        // Three shots, two hits each, Olast on the first beat.
        run_frame(3, 30, 2, 3, 0, 0);
        check("r033_start_pulses", -1, obs_start_rise, 3);
        check("r033_done_count",   -1, obs_done_cnt, 1);
        check("r033_drain_cycles", -1, obs_ready_cnt, 3);
        check("r033_last_shot",    -1, 32'(shot_cnt), 2);
        check("r033_hits",         -1, 32'(hit_cnt), 2);

        // Five hits saturate at three.
        run_frame(1, 40, 5, 2, 1, 0);
        check("r034_saturate", -1, 32'(hit_cnt), 3);

        // Range 0: an edge seen in the only window cycle is counted and forces DRAIN.
        run_frame(2, 0, 1, 0, 2, 0);
        check("range0_hit",   -1, 32'(hit_cnt), 1);
        check("range0_drain", -1, obs_ready_cnt, 6);

        // Edges just after the window and in the last START cycle are ignored.
        run_frame(1, 0, 1, 1, 0, 0);
        check("late_edge_hit",   -1, 32'(hit_cnt), 0);
        check("late_edge_drain", -1, obs_ready_cnt, 0);
        run_frame(2, 6, 1, -1, 0, 0);
        check("early_edge_drain", -1, obs_ready_cnt, 0);

        // shot_num 0 runs one shot; frame_req noise while busy is ignored throughout.
        run_frame(0, 12, 3, 0, 1, 0);
        check("shot0_pulses", -1, obs_start_rise, 1);
        check("shot0_done",   -1, obs_done_cnt, 1);
        check("shot0_index",  -1, 32'(shot_cnt), 0);

        // Reset mid-WINDOW and mid-DRAIN, each followed by a clean restart from shot 0.
        run_frame(3, 20, 2, 2, 0, 1);
        run_frame(2, 8, 1, 1, 0, 0);
        check("restart_w_done", -1, obs_done_cnt, 1);
        run_frame(3, 10, 2, 2, 8, 2);
        run_frame(2, 8, 2, 1, 1, 0);
        check("restart_d_done", -1, obs_done_cnt, 1);

        for (int i = 0; i < 8; i++) begin
            run_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 4)) - 1,
                      int'($urandom_range(0, 5)), 0);
            check("rand_done_count", i, obs_done_cnt, 1);
        end

`ifdef DRAIN_TIMEOUT_EN
        // Olast never arrives: err rises TIMEOUT cycles into DRAIN, frame still completes.
        run_frame(1, 10, 1, 2, -1, 0);
        check("timeout_err",  -1, 32'(err), 1);
        check("timeout_done", -1, obs_done_cnt, 1);
        run_frame(1, 5, 0, 0, 0, 0);
        check("timeout_clear", -1, 32'(err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
